// File: rtl/bcd_countdown_loader.sv
// ---------------------------------------------------------------------------
// bcd_countdown_loader
//   Loads a two-digit BCD preset and counts it down to 00 at a prescaled rate.
//   It sits at the consumer end of the add/sub preset bus. Its expired pulse is
//   wired back as the clear request for the preset logic.
//
// Parameters:
//   TICK_DIV  clock cycles per count step (>= 2)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   preset   in   [7:4] tens, [3:0] units BCD preset
//   load     in   capture preset (ignored while running)
//   start    in   begin/resume counting (needs count != 00)
//   pause    in   level; freezes counting while running
//   count    out  current BCD value, same layout as preset
//   running  out  high while state is RUN
//   expired  out  one-cycle pulse when a run reaches 00
//   busy     out  high in RUN or PAUSE
// ---------------------------------------------------------------------------
module bcd_countdown_loader #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] preset,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] count,
    output logic       running,
    output logic       expired,
    output logic       busy
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOADED, S_RUN, S_PAUSE, S_DONE
    } state_t;

    state_t        r_state, w_nxt_state;
    logic [7:0]    r_count, w_nxt_count;
    logic [PW-1:0] r_psc, w_nxt_psc;
    logic          r_expired, w_nxt_expired;
    logic          r_running, r_busy;

    logic [7:0]    w_sanitised;
    logic [7:0]    w_dec;
    logic          w_tick;

    // Clamp each digit to 9 so the count never holds a non-BCD code.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // One BCD step down; saturates at 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] c);
        if (c == 8'h00)
            return 8'h00;
        else if (c[3:0] != 4'd0)
            return {c[7:4], c[3:0] - 4'd1};
        else
            return {c[7:4] - 4'd1, 4'd9};
    endfunction

    assign w_sanitised = {clamp_digit(preset[7:4]), clamp_digit(preset[3:0])};
    assign w_dec       = bcd_dec(r_count);
    assign w_tick      = (r_psc == TICK_MAX);

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_count   = r_count;
        w_nxt_psc     = r_psc;
        w_nxt_expired = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (load) begin
                    w_nxt_state = S_LOADED;
                    w_nxt_count = w_sanitised;
                    w_nxt_psc   = '0;
                end
            end
            S_LOADED, S_PAUSE: begin
                // Load beats start; resuming from PAUSE keeps the prescaler phase.
                if (load) begin
                    w_nxt_state = S_LOADED;
                    w_nxt_count = w_sanitised;
                    w_nxt_psc   = '0;
                end else if (start && (r_count != 8'h00)) begin
                    w_nxt_state = S_RUN;
                    if (r_state == S_LOADED)
                        w_nxt_psc = '0;
                end
            end
            S_RUN: begin
                // The prescaler keeps counting on the edge that samples pause,
                // so a coinciding tick still decrements before pausing.
                if (w_tick) begin
                    w_nxt_psc   = '0;
                    w_nxt_count = w_dec;
                end else begin
                    w_nxt_psc = r_psc + 1'b1;
                end
                if (w_tick && (w_dec == 8'h00)) begin
                    w_nxt_state   = S_DONE;
                    w_nxt_expired = 1'b1;
                end else if (pause) begin
                    w_nxt_state = S_PAUSE;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= 8'h00;
            r_psc     <= '0;
            r_expired <= 1'b0;
            r_running <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_count   <= w_nxt_count;
            r_psc     <= w_nxt_psc;
            r_expired <= w_nxt_expired;
            r_running <= (w_nxt_state == S_RUN);
            r_busy    <= (w_nxt_state == S_RUN) || (w_nxt_state == S_PAUSE);
        end
    end

    assign count   = r_count;
    assign running = r_running;
    assign expired = r_expired;
    assign busy    = r_busy;

endmodule

// File: tb/tb_bcd_countdown_loader.sv
// ---------------------------------------------------------------------------
// tb_bcd_countdown_loader
//   Directed bench for bcd_countdown_loader with TICK_DIV=4. Inputs change
//   1 time unit after a rising edge; outputs are checked at the same point,
//   so each check sees the result of the preceding edge.
// ---------------------------------------------------------------------------
module tb_bcd_countdown_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] preset;
    logic       load, start, pause;
    logic [7:0] count;
    logic       running, expired, busy;

    int checks   = 0;
    int failures = 0;

    bcd_countdown_loader #(.TICK_DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .preset  (preset),
        .load    (load),
        .start   (start),
        .pause   (pause),
        .count   (count),
        .running (running),
        .expired (expired),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] p);
        preset = p;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; preset = 8'h00; load = 0; start = 0; pause = 0;
        #1;
        tick(2);
        chk("rst_count",   count,   8'h00);
        chk("rst_running", {7'b0, running}, 8'h00);
        chk("rst_busy",    {7'b0, busy},    8'h00);
        chk("rst_expired", {7'b0, expired}, 8'h00);
        reset = 1'b0;

        // Reset mid-run
        do_load(8'h25);
        chk("mr_load", count, 8'h25);
        do_start();
        chk("mr_running", {7'b0, running}, 8'h01);
        tick(5);
        chk("mr_count", count, 8'h24);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_rst_count",   count, 8'h00);
        chk("mr_rst_running", {7'b0, running}, 8'h00);
        chk("mr_rst_busy",    {7'b0, busy},    8'h00);
        chk("mr_rst_expired", {7'b0, expired}, 8'h00);

        // Basic run 03 -> 00
        do_load(8'h03);
        do_start();
        chk("br_t0", count, 8'h03);
        chk("br_busy", {7'b0, busy}, 8'h01);
        tick(3);
        chk("br_t3", count, 8'h03);
        tick();
        chk("br_t4", count, 8'h02);
        tick(4);
        chk("br_t8", count, 8'h01);
        tick(3);
        chk("br_t11_exp", {7'b0, expired}, 8'h00);
        tick();
        chk("br_t12", count, 8'h00);
        chk("br_t12_exp", {7'b0, expired}, 8'h01);
        chk("br_t12_run", {7'b0, running}, 8'h00);
        chk("br_t12_busy", {7'b0, busy}, 8'h00);
        tick();
        chk("br_t13_exp", {7'b0, expired}, 8'h00);
        do_start();
        chk("done_start_run", {7'b0, running}, 8'h00);
        chk("done_start_cnt", count, 8'h00);

        // Borrow and load-ignored-in-RUN
        do_load(8'h10);
        do_start();
        tick(4);
        chk("bo_09", count, 8'h09);
        do_load(8'h20);
        chk("run_load_ign", count, 8'h09);
        tick(3);
        chk("run_load_cont", count, 8'h08);
        pause = 1'b1;
        tick();
        pause = 1'b0;
        chk("pz_busy", {7'b0, busy}, 8'h01);
        chk("pz_running", {7'b0, running}, 8'h00);
        do_load(8'h20);
        chk("pz_load", count, 8'h20);
        chk("pz_load_busy", {7'b0, busy}, 8'h00);
        do_start();
        tick(4);
        chk("bo_19", count, 8'h19);
        tick(4);
        chk("bo_18", count, 8'h18);
        pause = 1'b1;
        tick();
        pause = 1'b0;

        // Pause / resume keeps prescaler phase
        do_load(8'h05);
        do_start();
        tick();
        pause = 1'b1;
        tick();
        chk("pr_paused_run", {7'b0, running}, 8'h00);
        tick(9);
        pause = 1'b0;
        chk("pr_hold", count, 8'h05);
        tick(2);
        chk("pr_no_resume", {7'b0, running}, 8'h00);
        chk("pr_busy", {7'b0, busy}, 8'h01);
        do_start();
        chk("pr_resume_run", {7'b0, running}, 8'h01);
        tick();
        chk("pr_r1", count, 8'h05);
        tick();
        chk("pr_r2", count, 8'h04);
        tick(15);
        chk("pr_01", count, 8'h01);
        chk("pr_01_exp", {7'b0, expired}, 8'h00);
        tick();
        chk("pr_00", count, 8'h00);
        chk("pr_00_exp", {7'b0, expired}, 8'h01);
        chk("pr_00_run", {7'b0, running}, 8'h00);
        tick();
        chk("pr_exp_end", {7'b0, expired}, 8'h00);

        // Load+start same cycle with clamping
        preset = 8'h3C; load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        chk("ls_count", count, 8'h39);
        chk("ls_running", {7'b0, running}, 8'h00);
        chk("ls_busy", {7'b0, busy}, 8'h00);
        do_start();
        chk("ls_then_run", {7'b0, running}, 8'h01);
        pause = 1'b1;
        tick();
        pause = 1'b0;
        do_load(8'hF2);
        chk("clamp_f2", count, 8'h92);

        // Preset 00: start ignored, no expiry
        do_load(8'h00);
        chk("z_count", count, 8'h00);
        do_start();
        chk("z_run", {7'b0, running}, 8'h00);
        chk("z_busy", {7'b0, busy}, 8'h00);
        for (int i = 0; i < 6; i++) begin
            chk("z_exp", {7'b0, expired}, 8'h00);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_loader.md
Name: bcd_countdown_loader

Overview:
- Consumer end of the two-digit BCD preset bus produced by the add/sub preset adder (8-bit preset: tens digit in [7:4], units digit in [3:0]).
- Loads the preset into internal digit flip-flops and counts down to 00 at a prescaled tick rate.
- Pulses `expired` at 00. The team wires `expired` back as the clear/reset request for the preset logic.

Parameters:
- TICK_DIV, 4, clock cycles per count step. Must be >= 2. Prescaler width is clog2(TICK_DIV).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- preset  input  8  BCD preset: [7:4] tens, [3:0] units
- load  input  1  capture preset into count (single-cycle strobe or level)
- start  input  1  begin/resume counting
- pause  input  1  level; freezes counting while high in RUN
- count  output  8  current BCD value, same digit layout as preset
- running  output  1  high while state is RUN
- expired  output  1  one-cycle pulse when count reaches 00 from a run
- busy  output  1  high in RUN or PAUSE

Behaviour:
- Reset values: state=IDLE, count=8'h00, prescaler=0, running=0, expired=0, busy=0. Reset overrides every other input in the same cycle, including a mid-run reset.
- States: IDLE, LOADED, RUN, PAUSE, DONE.
- Load:
  - Accepted in IDLE, LOADED, PAUSE and DONE; ignored in RUN.
  - Takes effect next edge: count<=sanitised preset, state->LOADED, prescaler<=0.
  - Sanitise: any digit >9 is clamped to 9 (e.g. 8'h3C -> 8'h39; 8'hF2 -> 8'h92).
- Start:
  - Accepted in LOADED or PAUSE when count!=00: state->RUN.
  - From LOADED, prescaler<=0. From PAUSE, the prescaler value is kept.
  - Start with count==00 is ignored and the state is unchanged.
- Load and start in the same cycle: load wins, start is ignored, state->LOADED.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler==TICK_DIV-1, prescaler<=0 and count decrements by one BCD step.
  - First decrement occurs TICK_DIV cycles after the start edge.
- BCD decrement:
  - units!=0: units-1.
  - units==0: units<=9 and tens-1.
  - Never wraps below 00.
- Expiry:
  - On the edge where count becomes 00, state->DONE and expired=1 for exactly that following cycle.
  - running deasserts on the same edge.
- Pause:
  - pause high in RUN -> PAUSE at next edge; count and prescaler are held.
  - pause low in PAUSE does not resume; an explicit start is required.
  - If pause and tick coincide, the decrement for that tick still occurs, then the state enters PAUSE. If that decrement reaches 00, DONE/expired take priority over PAUSE.
- DONE: holds count=00 until load or reset; start is ignored.
- Outputs are all registered. `count` reflects the state after the edge; no combinational path from inputs to outputs.
- Preset of 8'h00 loads into LOADED with count 00; a following start is ignored.

Test Plan:
- Reset mid-run: load 8'h25, start, reset asserted after 5 cycles -> next edge count=00, state IDLE, running=0, busy=0, expired=0.
- Basic run (TICK_DIV=4): load 8'h03, start at cycle t -> count 02 at t+4, 01 at t+8, 00 at t+12. expired high only in cycle t+12..t+13, running=0 from t+12, state DONE.
- Borrow: load 8'h10, start -> after 4 cycles count=8'h09. Load 8'h20, run 2 ticks -> 8'h19 then 8'h18.
- Pause/resume: load 8'h05, start, pause high 2 cycles after start for 10 cycles -> count stays 05. Start -> 04 appears 2 cycles later (prescaler preserved), and the run continues to 00 with expired.
- Precedence and clamps: load+start same cycle with preset 8'h3C -> count=8'h39, state LOADED, running=0. Load 8'h00 then start -> no state change, expired never pulses. Load during RUN -> ignored, count continues decrementing.
